// File: rtl/libhdl_ddr_tx_ctrl_if.sv
// rtl/libhdl_ddr_tx_ctrl_if.sv - word stream interface feeding the DDR TX burst sequencer
interface libhdl_ddr_tx_ctrl_if #(
    parameter int N = 1
) ();
    logic [2*N-1:0] tdata;
    logic           tvalid;
    logic           tready;
    logic           tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/libhdl_ddr_tx_ctrl.sv
// rtl/libhdl_ddr_tx_ctrl.sv - PRE/DATA/POST burst sequencer for an N-lane SDR-to-DDR cell (option: LIBHDL_DDR_TX_CTRL_STATS_EN)
module libhdl_ddr_tx_ctrl #(
    parameter int N           = 1,
    parameter int PRE_CYCLES  = 1,
    parameter int POST_CYCLES = 1
) (
    input  logic                 i_ck,
    input  logic                 i_rst,
    libhdl_ddr_tx_ctrl_if.slave  s_axis,
    output logic [2*N-1:0]       o_ddr_d,
    output logic                 o_ddr_oe,
    output logic                 o_busy,
    output logic                 o_underrun,
    input  logic                 i_clr_err
`ifdef LIBHDL_DDR_TX_CTRL_STATS_EN
    ,
    output logic [15:0]          o_burst_cnt,
    output logic [31:0]          o_beat_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_t;

    // Terminal counts; counter restarts at 0 on every phase entry so it never wraps.
    localparam logic [3:0]     PRE_LAST  = 4'(PRE_CYCLES - 1);
    localparam logic [3:0]     POST_LAST = 4'((POST_CYCLES > 0) ? (POST_CYCLES - 1) : 0);
    localparam logic [2*N-1:0] PRE_WORD  = {N{2'b10}};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_nxt;
    logic           w_ready;
    logic           w_hs;
    logic [2*N-1:0] w_ddr_d_nxt;
    logic           w_ddr_oe_nxt;
    logic           w_underrun_set;
    logic [2*N-1:0] r_ddr_d;
    logic           r_ddr_oe;
    logic           r_underrun;

    assign w_hs = s_axis.tvalid & w_ready;

    // State and phase counter register.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and phase counter decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (s_axis.tvalid) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_PRE: begin
                if (r_cnt == PRE_LAST) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_DATA: begin
                if (w_hs && s_axis.tlast) begin
                    w_state_nxt = (POST_CYCLES == 0) ? ST_IDLE : ST_POST;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_POST: begin
                if (r_cnt == POST_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Per-state output decisions; pad signals take effect one edge later.
    always_comb begin
        w_ready        = (r_state == ST_DATA);
        w_ddr_d_nxt    = '0;
        w_ddr_oe_nxt   = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            ST_PRE: begin
                w_ddr_d_nxt  = PRE_WORD;
                w_ddr_oe_nxt = 1'b1;
            end
            ST_DATA: begin
                w_ddr_oe_nxt = 1'b1;
                if (s_axis.tvalid) begin
                    w_ddr_d_nxt = s_axis.tdata;
                end else begin
                    w_underrun_set = 1'b1;
                end
            end
            ST_POST: begin
                w_ddr_oe_nxt = 1'b1;
            end
            default: begin
                w_ddr_oe_nxt = 1'b0;
            end
        endcase
    end

    // Registered D bus and output-enable toward the DDR cell; reset aborts without postamble.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_ddr_d  <= '0;
            r_ddr_oe <= 1'b0;
        end else begin
            r_ddr_d  <= w_ddr_d_nxt;
            r_ddr_oe <= w_ddr_oe_nxt;
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end else if (i_clr_err) begin
            r_underrun <= 1'b0;
        end
    end

    assign s_axis.tready = w_ready;
    assign o_ddr_d       = r_ddr_d;
    assign o_ddr_oe      = r_ddr_oe;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_underrun    = r_underrun;

`ifdef LIBHDL_DDR_TX_CTRL_STATS_EN
    logic [15:0] r_burst_cnt;
    logic [31:0] r_beat_cnt;

    // Free-running burst and beat statistics, wrapping naturally.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_burst_cnt <= 16'd0;
            r_beat_cnt  <= 32'd0;
        end else begin
            if (r_state == ST_IDLE && s_axis.tvalid) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
            if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    assign o_burst_cnt = r_burst_cnt;
    assign o_beat_cnt  = r_beat_cnt;
`endif

endmodule
